// File: rtl/risc8_uart_pkg.sv
// risc8_uart_pkg: frame constants and the line-state encoding shared by the
// risc8 UART transmitter and receiver.
package risc8_uart_pkg;

  localparam int unsigned DATA_BITS   = 8;
  localparam int unsigned BIT_IDX_W   = $clog2(DATA_BITS);
  localparam logic        START_LEVEL = 1'b0;
  localparam logic        STOP_LEVEL  = 1'b1;
  localparam logic        IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/risc8_uart_bit_timer.sv
// risc8_uart_bit_timer: loadable down-counter that ticks for one cycle at
// terminal count and then reloads itself for the next bit period.
module risc8_uart_bit_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_run,
  input  logic [W-1:0] i_reload_val,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_run) begin
      r_cnt <= (r_cnt == '0) ? i_reload_val : r_cnt - W'(1);
    end
  end

  assign o_tick = i_run && (r_cnt == '0);

endmodule

// File: rtl/risc8_uart.sv
// risc8_uart: 8N1 serial transmitter for the risc8 IO space, bit period
// baud_div+1 cycles. Define UART_RX_EN to also build the receiver.
module risc8_uart
  import risc8_uart_pkg::*;
#(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 tx_strobe,
  input  logic [7:0]           tx_data,
  output logic                 tx_ready,
  output logic                 tx_out
`ifdef UART_RX_EN
  ,
  input  logic                 rx_in,
  output logic [7:0]           rx_data,
  output logic                 rx_strobe
`endif
);

  uart_state_t            r_tx_state;
  logic [DATA_BITS-1:0]   r_tx_shift;
  logic [BIT_IDX_W-1:0]   r_tx_bit;
  logic [DIV_WIDTH-1:0]   r_tx_div;
  logic                   w_tx_accept;
  logic                   w_tx_run;
  logic                   w_tx_tick;

  assign w_tx_accept = (r_tx_state == IDLE) && tx_strobe;
  assign w_tx_run    = (r_tx_state != IDLE);

  // Divisor is captured at accept so later baud_div writes only affect the next frame.
  risc8_uart_bit_timer #(.W(DIV_WIDTH)) u_tx_timer (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_load       (w_tx_accept),
    .i_load_val   (baud_div),
    .i_run        (w_tx_run),
    .i_reload_val (r_tx_div),
    .o_tick       (w_tx_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_state <= IDLE;
      r_tx_shift <= '0;
      r_tx_bit   <= '0;
      r_tx_div   <= '0;
      tx_out     <= IDLE_LEVEL;
      tx_ready   <= 1'b1;
    end else begin
      unique case (r_tx_state)
        IDLE: begin
          if (tx_strobe) begin
            r_tx_shift <= tx_data;
            r_tx_div   <= baud_div;
            r_tx_bit   <= '0;
            tx_out     <= START_LEVEL;
            tx_ready   <= 1'b0;
            r_tx_state <= START;
          end
        end
        START: begin
          if (w_tx_tick) begin
            tx_out     <= r_tx_shift[0];
            r_tx_state <= DATA;
          end
        end
        DATA: begin
          if (w_tx_tick) begin
            if (r_tx_bit == BIT_IDX_W'(DATA_BITS - 1)) begin
              tx_out     <= STOP_LEVEL;
              r_tx_state <= STOP;
            end else begin
              tx_out     <= r_tx_shift[1];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_bit   <= r_tx_bit + BIT_IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (w_tx_tick) begin
            tx_out     <= IDLE_LEVEL;
            tx_ready   <= 1'b1;
            r_tx_state <= IDLE;
          end
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_EN
  localparam logic [DIV_WIDTH:0] ONE_EXT = 1;

  logic                   r_rx_meta;
  logic                   r_rx_sync;
  logic                   r_rx_prev;
  uart_state_t            r_rx_state;
  logic [DATA_BITS-1:0]   r_rx_shift;
  logic [BIT_IDX_W-1:0]   r_rx_bit;
  logic [DIV_WIDTH-1:0]   r_rx_div;
  logic [DIV_WIDTH:0]     w_rx_half;
  logic [DIV_WIDTH-1:0]   w_rx_first;
  logic                   w_rx_start;
  logic                   w_rx_run;
  logic                   w_rx_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= IDLE_LEVEL;
      r_rx_sync <= IDLE_LEVEL;
      r_rx_prev <= IDLE_LEVEL;
    end else begin
      r_rx_meta <= rx_in;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_comb begin
    w_rx_half  = ({1'b0, baud_div} + ONE_EXT) >> 1;
    w_rx_first = '0;
    if (w_rx_half != '0) begin
      w_rx_first = DIV_WIDTH'(w_rx_half - ONE_EXT);
    end
  end

  // A start needs a high-to-low transition, so after a framing error the
  // receiver stays idle until the line has gone high again.
  assign w_rx_start = (r_rx_state == IDLE) && r_rx_prev && !r_rx_sync;
  assign w_rx_run   = (r_rx_state != IDLE);

  risc8_uart_bit_timer #(.W(DIV_WIDTH)) u_rx_timer (
    .i_clk        (clk),
    .i_rst_n      (reset),
    .i_load       (w_rx_start),
    .i_load_val   (w_rx_first),
    .i_run        (w_rx_run),
    .i_reload_val (r_rx_div),
    .o_tick       (w_rx_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_state <= IDLE;
      r_rx_shift <= '0;
      r_rx_bit   <= '0;
      r_rx_div   <= '0;
      rx_data    <= '0;
      rx_strobe  <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      unique case (r_rx_state)
        IDLE: begin
          if (w_rx_start) begin
            r_rx_div <= baud_div;
            r_rx_bit <= '0;
            // Half period of zero: the start bit is confirmed by the edge itself.
            r_rx_state <= (w_rx_half == '0) ? DATA : START;
          end
        end
        START: begin
          if (w_rx_tick) begin
            r_rx_state <= (r_rx_sync == START_LEVEL) ? DATA : IDLE;
          end
        end
        DATA: begin
          if (w_rx_tick) begin
            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_bit == BIT_IDX_W'(DATA_BITS - 1)) begin
              r_rx_state <= STOP;
            end else begin
              r_rx_bit <= r_rx_bit + BIT_IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (w_rx_tick) begin
            if (r_rx_sync == STOP_LEVEL) begin
              rx_data   <= r_rx_shift;
              rx_strobe <= 1'b1;
            end
            r_rx_state <= IDLE;
          end
        end
        default: r_rx_state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_risc8_uart.sv
// tb_risc8_uart: directed and randomized checks of the risc8 UART against a
// per-cycle line model; receiver checks are built when UART_RX_EN is defined.
module tb_risc8_uart;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] baud_div;
  logic       tx_strobe;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam int unsigned NONE = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

`ifdef UART_RX_EN
  logic       rx_loop;
  logic       rx_drv;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_strobe;
  logic [7:0] rx_q[$];

  assign rx_in = rx_loop ? tx_out : rx_drv;

  always @(negedge clk) begin
    if (rx_strobe) rx_q.push_back(rx_data);
  end
`endif

  risc8_uart #(.DIV_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_div  (baud_div),
    .tx_strobe (tx_strobe),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_out    (tx_out)
`ifdef UART_RX_EN
    ,
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_strobe (rx_strobe)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] line_state();
    return {14'b0, tx_ready, tx_out};
  endfunction

  // Expected line level c cycles after the accept edge: bit index c/(d+1).
  function automatic logic exp_line(input logic [7:0] b, input int unsigned d,
                                    input int unsigned c);
    int unsigned idx;
    idx = c / (d + 1);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] b, input int unsigned d);
    baud_div  = 8'(d);
    tx_data   = b;
    tx_strobe = 1'b1;
    step();
    tx_strobe = 1'b0;
  endtask

  // Called in cycle 0 of a frame; at poke_at a stray strobe and a new baud_div are applied.
  task automatic check_frame(input logic [7:0] b, input int unsigned d,
                             input int unsigned poke_at, input logic [7:0] poke_data);
    for (int unsigned c = 0; c < 10 * (d + 1); c++) begin
      chk("frame_bit", line_state(), {14'b0, 1'b0, exp_line(b, d, c)});
      tx_strobe = (c == poke_at);
      if (c == poke_at) begin
        tx_data  = poke_data;
        baud_div = 8'($urandom_range(0, 15));
      end
      step();
    end
    tx_strobe = 1'b0;
    chk("ready_after_frame", line_state(), 16'h0003);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  b;
    int unsigned d;

    reset     = 1'b0;
    baud_div  = 8'd0;
    tx_strobe = 1'b0;
    tx_data   = 8'd0;
`ifdef UART_RX_EN
    rx_loop = 1'b1;
    rx_drv  = 1'b1;
`endif
    repeat (3) step();
    chk("reset_tx", line_state(), 16'h0003);
`ifdef UART_RX_EN
    chk("reset_rx", {7'b0, rx_strobe, rx_data}, 16'h0000);
`endif
    reset = 1'b1;
    repeat (4) begin
      step();
      chk("idle_after_reset", line_state(), 16'h0003);
    end

    start(8'h55, 5);
    check_frame(8'h55, 5, NONE, 8'h00);

    start(8'hA3, 5);
    check_frame(8'hA3, 5, 10, 8'hFF);

    start(8'h01, 0);
    check_frame(8'h01, 0, NONE, 8'h00);
    start(8'h80, 0);
    check_frame(8'h80, 0, NONE, 8'h00);

    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      d = $urandom_range(0, 7);
      start(b, d);
      check_frame(b, d, $urandom_range(0, 10 * (d + 1) - 2), 8'($urandom));
    end

    start(8'h00, 5);
    for (int unsigned c = 0; c < 15; c++) begin
      chk("pre_reset_bit", line_state(), {14'b0, 1'b0, exp_line(8'h00, 5, c)});
      step();
    end
    reset = 1'b0;
    #1;
    chk("reset_mid_frame", line_state(), 16'h0003);
    step();
    step();
    reset = 1'b1;
    repeat (30) begin
      step();
      chk("no_restart_after_reset", line_state(), 16'h0003);
    end

`ifdef UART_RX_EN
    repeat (10) step();
    rx_q.delete();
    start(8'hC3, 5);
    check_frame(8'hC3, 5, NONE, 8'h00);
    repeat (20) step();
    chk("rx_loop_count", 16'(rx_q.size()), 16'd1);
    chk("rx_loop_data", {8'b0, rx_data}, 16'h00C3);

    for (int i = 0; i < 4; i++) begin
      rx_q.delete();
      b = 8'($urandom);
      d = $urandom_range(0, 9);
      start(b, d);
      check_frame(b, d, NONE, 8'h00);
      repeat (20) step();
      chk("rx_rand_count", 16'(rx_q.size()), 16'd1);
      chk("rx_rand_data", {8'b0, rx_data}, {8'b0, b});
    end

    rx_loop  = 1'b0;
    rx_drv   = 1'b1;
    baud_div = 8'd5;
    repeat (5) step();
    rx_q.delete();
    rx_drv = 1'b0;
    step();
    step();
    rx_drv = 1'b1;
    repeat (30) step();
    chk("rx_glitch_no_strobe", 16'(rx_q.size()), 16'd0);

    b = 8'($urandom);
    for (int unsigned c = 0; c < 60; c++) begin
      rx_drv = (c / 6 == 0 || c / 6 == 9) ? 1'b0 : b[c/6 - 1];
      step();
    end
    rx_drv = 1'b0;
    repeat (12) step();
    rx_drv = 1'b1;
    repeat (40) step();
    chk("rx_framing_no_strobe", 16'(rx_q.size()), 16'd0);

    rx_loop = 1'b1;
    b = 8'($urandom);
    start(b, 5);
    check_frame(b, 5, NONE, 8'h00);
    repeat (20) step();
    chk("rx_rearm_count", 16'(rx_q.size()), 16'd1);
    chk("rx_rearm_data", {8'b0, rx_data}, {8'b0, b});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
